// File: rtl/mm_host_pkg.sv
// ============================================================================
// Module  : mm_host_pkg
// Brief   : Shared constants and state encoding for the matmul stream host.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mm_host_pkg;

   localparam int MM_DW         = 8;
   localparam int MM_RW         = 16;
   localparam int MM_TIMEOUT    = 64;
   localparam int NUM_IN_BYTES  = 8;
   localparam int NUM_OUT_BYTES = 8;

   typedef logic [2:0] state_t;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_LOAD    = 3'd1;
   localparam logic [2:0] ST_RUN     = 3'd2;
   localparam logic [2:0] ST_RELEASE = 3'd3;
   localparam logic [2:0] ST_SEND    = 3'd4;

endpackage

`default_nettype wire

// File: rtl/matmul_stream_host.sv
// ============================================================================
// Module  : matmul_stream_host
// Brief   : Byte-stream loader, start/done initiator and result serializer
//           for the 2x2 sequential matrix multiplier.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module matmul_stream_host
   import mm_host_pkg::*;
#(
   parameter int DW      = MM_DW,
   parameter int RW      = MM_RW,
   parameter int TIMEOUT = MM_TIMEOUT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            s_valid,
   output logic            s_ready,
   input  logic [DW-1:0]   s_data,
   output logic            m_valid,
   input  logic            m_ready,
   output logic [DW-1:0]   m_data,
   output logic [4*DW-1:0] mm_a,
   output logic [4*DW-1:0] mm_b,
   output logic            mm_start,
   input  logic [4*RW-1:0] mm_c,
   input  logic            mm_done,
   output logic            busy,
   output logic            timeout_err
);

   localparam int CW = $clog2(TIMEOUT + 1);

   state_t            state;
   logic [2:0]        load_idx;
   logic [2:0]        send_idx;
   logic [CW-1:0]     cnt;
   logic [4*RW-1:0]   result;
   logic [RW-1:0]     res_word;
   logic [DW-1:0]     res_byte;

   assign s_ready = (state == ST_LOAD);
   assign m_valid = (state == ST_SEND);
   assign busy    = (state != ST_IDLE) && (state != ST_LOAD);

   always_comb begin
      res_word = result[RW-1:0];
      case (send_idx[2:1])
         2'd0:    res_word = result[0*RW +: RW];
         2'd1:    res_word = result[1*RW +: RW];
         2'd2:    res_word = result[2*RW +: RW];
         default: res_word = result[3*RW +: RW];
      endcase
      res_byte = send_idx[0] ? res_word[DW +: DW] : res_word[0 +: DW];
   end

   // Output bus is forced to zero outside SEND so idle traffic is clean
   assign m_data = m_valid ? res_byte : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         load_idx    <= '0;
         send_idx    <= '0;
         cnt         <= '0;
         result      <= '0;
         mm_a        <= '0;
         mm_b        <= '0;
         mm_start    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: state <= ST_LOAD;

            ST_LOAD: begin
               if (s_valid) begin
                  if (load_idx == 3'd0)
                     timeout_err <= 1'b0;
                  if (!load_idx[2])
                     mm_a[int'(load_idx[1:0])*DW +: DW] <= s_data;
                  else
                     mm_b[int'(load_idx[1:0])*DW +: DW] <= s_data;
                  if (load_idx == 3'(NUM_IN_BYTES - 1)) begin
                     load_idx <= '0;
                     cnt      <= '0;
                     mm_start <= 1'b1;
                     state    <= ST_RUN;
                  end else begin
                     load_idx <= load_idx + 3'd1;
                  end
               end
            end

            ST_RUN: begin
               cnt <= cnt + 1'b1;
               if (mm_done) begin
                  result   <= mm_c;
                  mm_start <= 1'b0;
                  state    <= ST_RELEASE;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  mm_start    <= 1'b0;
                  timeout_err <= 1'b1;
                  state       <= ST_RELEASE;
               end
            end

            ST_RELEASE: begin
               // Saturate so a slow done release never wraps the counter
               if (cnt != '1)
                  cnt <= cnt + 1'b1;
               if (!mm_done)
                  state <= timeout_err ? ST_LOAD : ST_SEND;
            end

            ST_SEND: begin
               if (m_ready) begin
                  if (send_idx == 3'(NUM_OUT_BYTES - 1)) begin
                     send_idx <= '0;
                     state    <= ST_LOAD;
                  end else begin
                     send_idx <= send_idx + 3'd1;
                  end
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_matmul_stream_host.sv
// ============================================================================
// Module  : tb_matmul_stream_host
// Brief   : Directed self-checking bench with a behavioral 2x2 multiplier.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matmul_stream_host;

   localparam int DW  = 8;
   localparam int RW  = 16;
   localparam int LAT = 3;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            s_valid = 1'b0;
   logic            s_ready;
   logic [DW-1:0]   s_data = '0;
   logic            m_valid;
   logic            m_ready = 1'b0;
   logic [DW-1:0]   m_data;
   logic [4*DW-1:0] mm_a;
   logic [4*DW-1:0] mm_b;
   logic            mm_start;
   logic [4*RW-1:0] mm_c;
   logic            mm_done;
   logic            busy;
   logic            timeout_err;

   int checks   = 0;
   int failures = 0;

   logic [7:0] op [8];
   logic [7:0] exp_b [8];

   bit         tie_done0 = 1'b0;
   logic       mdl_busy;
   int         mdl_cnt;

   always #5 clk = ~clk;

   matmul_stream_host dut (
      .clk         (clk),
      .rst         (rst),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .mm_a        (mm_a),
      .mm_b        (mm_b),
      .mm_start    (mm_start),
      .mm_c        (mm_c),
      .mm_done     (mm_done),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   function automatic logic [4*RW-1:0] mult(input logic [4*DW-1:0] a, input logic [4*DW-1:0] b);
      int a11, a12, a21, a22, b11, b12, b21, b22;
      logic [31:0] c11, c12, c21, c22;
      a11 = int'(a[7:0]);   a12 = int'(a[15:8]);  a21 = int'(a[23:16]); a22 = int'(a[31:24]);
      b11 = int'(b[7:0]);   b12 = int'(b[15:8]);  b21 = int'(b[23:16]); b22 = int'(b[31:24]);
      c11 = 32'(a11*b11 + a12*b21);
      c12 = 32'(a11*b12 + a12*b22);
      c21 = 32'(a21*b11 + a22*b21);
      c22 = 32'(a21*b12 + a22*b22);
      return {c22[15:0], c21[15:0], c12[15:0], c11[15:0]};
   endfunction

   // Multiplier stand-in: done rises LAT+1 cycles after start, drops after start falls
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mm_done  <= 1'b0;
         mdl_busy <= 1'b0;
         mdl_cnt  <= 0;
         mm_c     <= '0;
      end else if (!mdl_busy && !mm_done && mm_start && !tie_done0) begin
         mdl_busy <= 1'b1;
         mdl_cnt  <= LAT;
      end else if (mdl_busy) begin
         if (mdl_cnt == 0) begin
            mdl_busy <= 1'b0;
            mm_done  <= 1'b1;
            mm_c     <= mult(mm_a, mm_b);
         end else begin
            mdl_cnt <= mdl_cnt - 1;
         end
      end else if (mm_done && !mm_start) begin
         mm_done <= 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      repeat (gap) @(negedge clk);
      s_valid = 1'b1;
      s_data  = b;
      n = 0;
      while (!s_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("s_ready_wait", 64'd0, 64'd1);
      @(posedge clk);
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic load_job(input int maxgap);
      for (int i = 0; i < 8; i++)
         send_byte(op[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
   endtask

   task automatic recv(input int first, input int num, input int maxstall);
      int n;
      int stall;
      logic [7:0] held;
      for (int i = first; i < first + num; i++) begin
         m_ready = 1'b0;
         n = 0;
         while (!m_valid && n < 200) begin
            @(negedge clk);
            n++;
         end
         if (n >= 200) chk("m_valid_wait", 64'd0, 64'd1);
         stall = (maxstall > 0) ? int'($urandom_range(0, maxstall)) : 0;
         repeat (stall) begin
            held = m_data;
            @(negedge clk);
            chk("stall_hold_data", 64'(m_data), 64'(held));
            chk("stall_hold_valid", 64'(m_valid), 64'd1);
         end
         chk($sformatf("out_byte%0d", i), 64'(m_data), 64'(exp_b[i]));
         m_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         m_ready = 1'b0;
      end
   endtask

   task automatic set_job1();
      op    = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
      exp_b = '{8'h13, 8'h00, 8'h16, 8'h00, 8'h2B, 8'h00, 8'h32, 8'h00};
   endtask

   initial begin
      int n;
      bit saw_mv;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_s_ready", 64'(s_ready), 64'd0);
      chk("rst_m_valid", 64'(m_valid), 64'd0);
      chk("rst_m_data", 64'(m_data), 64'd0);
      chk("rst_mm_start", 64'(mm_start), 64'd0);
      chk("rst_mm_ab", 64'({mm_a, mm_b}), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_timeout_err", 64'(timeout_err), 64'd0);
      rst = 1'b0;
      #1 chk("s_ready_first_cycle", 64'(s_ready), 64'd0);
      @(negedge clk);
      chk("s_ready_second_cycle", 64'(s_ready), 64'd1);

      // Job 1: small operands, no gaps
      set_job1();
      load_job(0);
      chk("mm_start_rise", 64'(mm_start), 64'd1);
      chk("busy_run", 64'(busy), 64'd1);
      chk("s_ready_run", 64'(s_ready), 64'd0);
      chk("mm_a_packed", 64'(mm_a), 64'h04030201);
      chk("mm_b_packed", 64'(mm_b), 64'h08070605);
      recv(0, 8, 0);
      chk("job1_timeout_err", 64'(timeout_err), 64'd0);
      chk("b2b_s_ready", 64'(s_ready), 64'd1);

      // Job 2: all 0xFF, truncated products, loaded back-to-back
      op    = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      exp_b = '{8'h02, 8'hFC, 8'h02, 8'hFC, 8'h02, 8'hFC, 8'h02, 8'hFC};
      load_job(0);
      recv(0, 8, 0);

      // Job 3: job 1 operands with input gaps and output stalls
      set_job1();
      load_job(5);
      recv(0, 8, 5);

      // Timeout: multiplier never answers
      tie_done0 = 1'b1;
      load_job(0);
      n = 0;
      saw_mv = 1'b0;
      while (mm_start && n < 200) begin
         saw_mv |= m_valid;
         n++;
         @(negedge clk);
      end
      chk("timeout_start_cycles", 64'(n), 64'd64);
      chk("timeout_err_set", 64'(timeout_err), 64'd1);
      @(negedge clk);
      chk("timeout_s_ready", 64'(s_ready), 64'd1);
      chk("timeout_no_m_valid", 64'(saw_mv | m_valid), 64'd0);
      tie_done0 = 1'b0;

      // Recovery job: first byte clears the sticky flag
      send_byte(op[0], 0);
      chk("timeout_err_cleared", 64'(timeout_err), 64'd0);
      for (int i = 1; i < 8; i++) send_byte(op[i], 0);
      recv(0, 8, 0);

      // Reset in the middle of SEND
      load_job(0);
      recv(0, 3, 0);
      #2 rst = 1'b1;
      #1;
      chk("midrst_s_ready", 64'(s_ready), 64'd0);
      chk("midrst_m_valid", 64'(m_valid), 64'd0);
      chk("midrst_m_data", 64'(m_data), 64'd0);
      chk("midrst_mm_start", 64'(mm_start), 64'd0);
      chk("midrst_mm_ab", 64'({mm_a, mm_b}), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      op    = '{8'd2, 8'd0, 8'd1, 8'd3, 8'd10, 8'd20, 8'd30, 8'd40};
      // c11=20 c12=40 c21=10+90=100 c22=20+120=140
      exp_b = '{8'h14, 8'h00, 8'h28, 8'h00, 8'h64, 8'h00, 8'h8C, 8'h00};
      load_job(0);
      recv(0, 8, 0);
      chk("final_timeout_err", 64'(timeout_err), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
